// File: rtl/fixed_point_divider_param.sv
// Sequential restoring divider for Qm.FRAC operands.
// One quotient bit per clock, with saturation and divide-by-zero flags.
module fixed_point_divider_param #(
   parameter int WIDTH  = 10,
   parameter int FRAC   = 5,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] q,
   output logic             ov,
   output logic             dz,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH + FRAC;
   localparam int CW = $clog2(N + 1);

   localparam logic [N-1:0] POS_MAX =
      {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [N-1:0] NEG_MAX = POS_MAX + 1'b1;

   localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] Q_ONE = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] rem;
   logic [N-1:0]     dvd;
   logic [CW-1:0]    count;
   logic             neg;
   logic             dz_p;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag_new;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             take;
   logic [WIDTH-1:0] q_nxt;
   logic             ov_nxt;

   // Operand magnitudes and signs from the stored registers
   always_comb begin
      a_neg     = (SIGNED != 0) && a_reg[WIDTH-1];
      b_neg     = (SIGNED != 0) && b_reg[WIDTH-1];
      a_mag     = a_neg ? -a_reg : a_reg;
      b_mag_new = b_neg ? -b_reg : b_reg;
   end

   // One restoring step: the low WIDTH bits suffice after subtraction
   always_comb begin
      rem_sh  = {rem, dvd[N-1]};
      take    = (rem_sh >= {1'b0, b_mag});
      rem_sub = rem_sh[WIDTH-1:0] - b_mag;
   end

   // Final quotient with sign restore and saturation
   always_comb begin
      q_nxt  = dvd[WIDTH-1:0];
      ov_nxt = 1'b0;
      if (dz_p) begin
         ov_nxt = 1'b1;
         if (SIGNED == 0)
            q_nxt = Q_ONE;
         else
            q_nxt = neg ? Q_MIN : Q_MAX;
      end else if (SIGNED == 0) begin
         if ((dvd >> WIDTH) != '0) begin
            ov_nxt = 1'b1;
            q_nxt  = Q_ONE;
         end
      end else if (neg) begin
         if (dvd > NEG_MAX) begin
            ov_nxt = 1'b1;
            q_nxt  = Q_MIN;
         end else begin
            q_nxt  = -dvd[WIDTH-1:0];
         end
      end else if (dvd > POS_MAX) begin
         ov_nxt = 1'b1;
         q_nxt  = Q_MAX;
      end
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         a_reg <= '0;
         b_reg <= '0;
         b_mag <= '0;
         rem   <= '0;
         dvd   <= '0;
         count <= '0;
         neg   <= 1'b0;
         dz_p  <= 1'b0;
         q     <= '0;
         ov    <= 1'b0;
         dz    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (ld_a) a_reg <= a_in;
               if (ld_b) b_reg <= b_in;
               if (start) begin
                  busy <= 1'b1;
                  if (b_reg == '0) begin
                     dz_p  <= 1'b1;
                     neg   <= a_neg;
                     state <= S_FIX;
                  end else begin
                     dz_p  <= 1'b0;
                     neg   <= a_neg ^ b_neg;
                     dvd   <= N'(a_mag) << FRAC;
                     rem   <= '0;
                     b_mag <= b_mag_new;
                     count <= CW'(N);
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               dvd   <= {dvd[N-2:0], take};
               rem   <= take ? rem_sub : rem_sh[WIDTH-1:0];
               count <= count - 1'b1;
               if (count == CW'(1)) state <= S_FIX;
            end
            S_FIX: begin
               q     <= q_nxt;
               ov    <= ov_nxt;
               dz    <= dz_p;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_point_divider_param.sv
// Bench for fixed_point_divider_param, unsigned and signed instances.
// Table vectors, random ops against a plain-arithmetic model, corners.
module tb_fixed_point_divider_param;

   localparam int W = 10;
   localparam int F = 5;

   logic         clk   = 1'b0;
   logic         rst   = 1'b0;
   logic         start = 1'b0;
   logic         ld_a  = 1'b0;
   logic         ld_b  = 1'b0;
   logic [W-1:0] a_in  = '0;
   logic [W-1:0] b_in  = '0;

   logic [W-1:0] q_u, q_s;
   logic         ov_u, ov_s, dz_u, dz_s;
   logic         busy_u, busy_s, done_u, done_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fixed_point_divider_param #(
      .WIDTH(W), .FRAC(F), .SIGNED(0)
   ) dut_u (
      .clk(clk), .rst(rst), .start(start),
      .ld_a(ld_a), .ld_b(ld_b),
      .a_in(a_in), .b_in(b_in),
      .q(q_u), .ov(ov_u), .dz(dz_u),
      .busy(busy_u), .done(done_u)
   );

   fixed_point_divider_param #(
      .WIDTH(W), .FRAC(F), .SIGNED(1)
   ) dut_s (
      .clk(clk), .rst(rst), .start(start),
      .ld_a(ld_a), .ld_b(ld_b),
      .a_in(a_in), .b_in(b_in),
      .q(q_s), .ov(ov_s), .dz(dz_s),
      .busy(busy_s), .done(done_s)
   );

   typedef struct {
      logic [W-1:0] q;
      logic         ov;
      logic         dz;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] qu;
      logic         ovu;
      logic         dzu;
      logic [W-1:0] qs;
      logic         ovs;
      logic         dzs;
      int           lat;
   } vec_t;

   // Real-valued quotient scaled by 2^F, truncated toward zero, then clamped
   function automatic res_t model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input bit sg);
      res_t   r;
      longint av, bv, qv;
      longint umax, smax, smin;
      umax = (longint'(1) << W) - 1;
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      av = sg ? longint'($signed(a)) : longint'(a);
      bv = sg ? longint'($signed(b)) : longint'(b);
      r.dz = (bv == 0);
      r.ov = 1'b0;
      r.q  = '0;
      if (bv == 0) begin
         r.ov = 1'b1;
         if (!sg)         r.q = umax[W-1:0];
         else if (av < 0) r.q = smin[W-1:0];
         else             r.q = smax[W-1:0];
      end else begin
         qv = (av * (longint'(1) << F)) / bv;
         if (!sg && qv > umax) begin
            r.ov = 1'b1;
            r.q  = umax[W-1:0];
         end else if (sg && qv > smax) begin
            r.ov = 1'b1;
            r.q  = smax[W-1:0];
         end else if (sg && qv < smin) begin
            r.ov = 1'b1;
            r.q  = smin[W-1:0];
         end else begin
            r.q  = qv[W-1:0];
         end
      end
      return r;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      a_in = a;
      b_in = b;
      ld_a = 1'b1;
      ld_b = 1'b1;
      @(negedge clk);
      ld_a = 1'b0;
      ld_b = 1'b0;
   endtask

   // Start, optionally disturb while busy, wait for done, check results
   task automatic go(input string tag,
                     input bit lda,
                     input logic [W-1:0] na,
                     input bit disturb,
                     input res_t eu,
                     input res_t es,
                     input int lat);
      int k;
      bit busy_ok;
      @(negedge clk);
      start = 1'b1;
      ld_a  = lda;
      a_in  = na;
      @(negedge clk);
      start = 1'b0;
      ld_a  = 1'b0;
      k = 0;
      busy_ok = 1'b1;
      while (!done_u && k < 60) begin
         if (!busy_u || !busy_s || done_s) busy_ok = 1'b0;
         if (disturb && k == 3) begin
            start = 1'b1;
            ld_a  = 1'b1;
            a_in  = ~na;
         end else begin
            start = 1'b0;
            ld_a  = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      ld_a  = 1'b0;
      chk({tag, " latency"}, k, lat);
      chk({tag, " busy_held"}, busy_ok, 1);
      chk({tag, " busy_at_done"}, {busy_u, busy_s}, 0);
      chk({tag, " done_s"}, done_s, 1);
      chk({tag, " q_u"}, q_u, eu.q);
      chk({tag, " ov_u"}, ov_u, eu.ov);
      chk({tag, " dz_u"}, dz_u, eu.dz);
      chk({tag, " q_s"}, q_s, es.q);
      chk({tag, " ov_s"}, ov_s, es.ov);
      chk({tag, " dz_s"}, dz_s, es.dz);
      @(negedge clk);
      chk({tag, " done_pulse"}, {done_u, done_s}, 0);
   endtask

   function automatic res_t mk(input logic [W-1:0] q,
                               input logic ov,
                               input logic dz);
      res_t r;
      r.q  = q;
      r.ov = ov;
      r.dz = dz;
      return r;
   endfunction

   initial begin
      #300_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tv[13];
      logic [W-1:0] ra, rb;
      bit seen;

      tv[0]  = '{10'h020, 10'h010, 10'h040, 0, 0, 10'h040, 0, 0, 16};
      tv[1]  = '{10'h3FF, 10'h001, 10'h3FF, 1, 0, 10'h3E0, 0, 0, 16};
      tv[2]  = '{10'h020, 10'h000, 10'h3FF, 1, 1, 10'h1FF, 1, 1, 1};
      tv[3]  = '{10'h3E0, 10'h010, 10'h3FF, 1, 0, 10'h3C0, 0, 0, 16};
      tv[4]  = '{10'h200, 10'h3E0, 10'h010, 0, 0, 10'h1FF, 1, 0, 16};
      tv[5]  = '{10'h3E0, 10'h000, 10'h3FF, 1, 1, 10'h200, 1, 1, 1};
      tv[6]  = '{10'h001, 10'h3FF, 10'h000, 0, 0, 10'h3E0, 0, 0, 16};
      tv[7]  = '{10'h200, 10'h3FF, 10'h010, 0, 0, 10'h1FF, 1, 0, 16};
      tv[8]  = '{10'h200, 10'h001, 10'h3FF, 1, 0, 10'h200, 1, 0, 16};
      tv[9]  = '{10'h3F0, 10'h020, 10'h3F0, 0, 0, 10'h3F0, 0, 0, 16};
      tv[10] = '{10'h200, 10'h020, 10'h200, 0, 0, 10'h200, 0, 0, 16};
      tv[11] = '{10'h3FF, 10'h040, 10'h1FF, 0, 0, 10'h000, 0, 0, 16};
      tv[12] = '{10'h1FF, 10'h020, 10'h1FF, 0, 0, 10'h1FF, 0, 0, 16};

      #2;
      chk("rst q", {q_u, q_s}, 0);
      chk("rst flags", {ov_u, dz_u, ov_s, dz_s}, 0);
      chk("rst hs", {busy_u, done_u, busy_s, done_s}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      foreach (tv[i]) begin
         load(tv[i].a, tv[i].b);
         go($sformatf("vec%0d", i), 1'b0, tv[i].a, 1'b0,
            mk(tv[i].qu, tv[i].ovu, tv[i].dzu),
            mk(tv[i].qs, tv[i].ovs, tv[i].dzs),
            tv[i].lat);
      end

      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         load(ra, rb);
         go($sformatf("rnd%0d", i), 1'b0, ra, 1'b0,
            model(ra, rb, 1'b0), model(ra, rb, 1'b1),
            (rb == '0) ? 1 : 16);
      end

      load(10'h020, 10'h010);
      go("hs_busy", 1'b0, 10'h020, 1'b1,
         model(10'h020, 10'h010, 1'b0),
         model(10'h020, 10'h010, 1'b1), 16);
      go("hs_keep_a", 1'b0, 10'h000, 1'b0,
         model(10'h020, 10'h010, 1'b0),
         model(10'h020, 10'h010, 1'b1), 16);
      go("hs_same_edge", 1'b1, 10'h040, 1'b0,
         model(10'h020, 10'h010, 1'b0),
         model(10'h020, 10'h010, 1'b1), 16);
      go("hs_new_a", 1'b0, 10'h000, 1'b0,
         model(10'h040, 10'h010, 1'b0),
         model(10'h040, 10'h010, 1'b1), 16);

      load(10'h020, 10'h010);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_abort busy", {busy_u, busy_s}, 2'b11);
      rst = 1'b0;
      #1;
      chk("abort q", {q_u, q_s}, 0);
      chk("abort flags", {ov_u, dz_u, ov_s, dz_s}, 0);
      chk("abort hs", {busy_u, done_u, busy_s, done_s}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done_u || done_s) seen = 1'b1;
      end
      chk("abort no_done", seen, 0);

      go("post_rst_clear", 1'b0, 10'h000, 1'b0,
         model(10'h000, 10'h000, 1'b0),
         model(10'h000, 10'h000, 1'b1), 1);
      load(10'h060, 10'h020);
      go("post_rst_fresh", 1'b0, 10'h060, 1'b0,
         model(10'h060, 10'h020, 1'b0),
         model(10'h060, 10'h020, 1'b1), 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
